cdr_symbol_tx: RTL and testbench
================================

# cdr_symbol_tx

Transmit-side stimulus source for the `cdr` receive core. It generates the signed 8-bit sample stream that the CDR consumes on `y_n`. A 32-bit NCO sets the baud rate. Symbols come either from an internal PRBS7 or from an external valid/ready source, are mapped to NRZ or Gray-coded PAM4 levels, and are edge-shaped by a first-order slew filter so the receiver sees real transitions. The block sits on the TX end of the same sample interface, in loopback benches and in on-chip self-test.

## Interface
- `AMP`, 96: outer level magnitude, 1..127. Inner PAM4 level is `AMP/3`, integer division at elaboration (96 → 32).
- `SHIFT`, 2: slew-filter shift, 0..4. A value of 0 means no shaping; the output steps directly to the level.
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `en`  in  1  run enable. When low, all state is frozen.
- `fcw`  in  32  baud frequency control word. Baud = f_clk·fcw/2^32.
- `pam4`  in  1  0 = NRZ (1 bit/symbol), 1 = PAM4 (2 bits/symbol).
- `src_ext`  in  1  0 = internal PRBS7, 1 = external symbol port.
- `ext_sym`  in  2  external symbol. NRZ uses `ext_sym[0]`.
- `ext_valid`  in  1  external symbol available.
- `ext_ready`  out  1  combinational; high in the cycle a symbol is fetched.
- `y_n`  out  8  signed shaped sample.
- `baud_stb`  out  1  one-cycle pulse per new symbol.
- `sym`  out  2  current symbol (NRZ: `{1'b0,bit}`).
- `underrun`  out  1  sticky external-starvation flag.

## Operation
- **NCO**
  - When `en=1`, each cycle `acc <= acc + fcw`, mod 2^32.
  - `tick` is the carry-out of that add.
  - `acc` is never reloaded on `fcw` change. A new `fcw` takes effect on the next add.
- **Symbol fetch** happens on a cycle with `tick=1`.
  - PRBS7:
    - polynomial x^7+x^6+1.
    - Per step: `nb = lfsr[6]^lfsr[5]`, `lfsr <= {lfsr[5:0],nb}`, output bit = `nb`.
    - NRZ takes one step per symbol. PAM4 takes two steps per symbol, with the first bit as the MSB.
  - External:
    - `ext_ready = en & tick & src_ext`.
    - If `ext_valid=1`, `sym <= ext_sym` (NRZ: `{0,ext_sym[0]}`).
    - If `ext_valid=0`, `sym` holds its previous value and `underrun <= 1`. `underrun` is cleared only by reset.
  - The LFSR advances only while `src_ext=0`.
  - Changes to `pam4` or `src_ext` take effect at the next fetch only.
- **Level mapping** (into the `target` register):
  - NRZ: 0 → −AMP, 1 → +AMP.
  - PAM4 (Gray): 00 → −AMP, 01 → −AMP/3, 11 → +AMP/3, 10 → +AMP.
- **Slew filter**, applied every `en` cycle:
  - `d = target − y`, computed in 9 bits.
  - If |d| < 2^SHIFT, then `y <= target`.
  - Otherwise `y <= y + (d >>> SHIFT)`, arithmetic shift.
  - `y` always stays between the old and new target, so no saturation is needed.
- **`en=0`:** `acc`, `lfsr`, `sym`, `target` and `y_n` hold. `baud_stb` and `ext_ready` are 0.

## Timing
- **Reset values:**
  - Internal state: `acc=0`, `lfsr=7'h7F`, `target=0`.
  - Outputs: `sym=0`, `y_n=0`, `baud_stb=0`, `underrun=0`, `ext_ready=0`.
  - `y_n` stays 0 until the first fetch.
- **Cycle sequence for a fetch:**
  - Cycle k has `tick=1`. At the end of cycle k, `sym`, `lfsr` and `target` update and `baud_stb` is registered to 1.
  - Cycle k+1: `baud_stb=1`, and `sym` shows the new symbol.
  - At the end of cycle k+1 `y_n` takes its first step toward the new target. With SHIFT=0, `y_n` equals the new level in cycle k+2.
- **Handshake:** the external transfer occurs at the rising edge ending the cycle where `ext_ready & ext_valid`. Exactly one transfer happens per tick.
- **Boundary conditions:**
  - `fcw=0`: no ticks ever.
  - `fcw=32'hFFFF_FFFF`: a tick every cycle, except the first cycle after reset.
  - A tick coinciding with `en` falling is not taken; it is re-evaluated when `en` returns.
  - Asserting reset mid-symbol or mid-slew returns everything to the reset values asynchronously.

## Test plan
- **Reset:** hold `rst_n=0` with `en=1`, `fcw=32'h4000_0000` → all outputs 0. After release, the first `baud_stb` appears at cycle 4 and then every 4 cycles.
- **NRZ PRBS7, SHIFT=0, AMP=96:**
  - Stimulus: `src_ext=0`, `pam4=0`, `fcw=32'h4000_0000`.
  - Response: the first six symbol levels are −96, the seventh is +96.
  - The bit sequence repeats with period 127 symbols, and the LFSR never reaches all-zero.
- **PAM4 external, SHIFT=0:**
  - Stimulus: `ext_sym` 10, 11, 01, 00 with `ext_valid=1`.
  - Response: `y_n` = +96, +32, −32, −96. `ext_ready` pulses exactly once per `baud_stb`.
- **Underrun:** drop `ext_valid` across one tick → `sym` and `y_n` repeat the previous level, and `underrun=1` stays set after `ext_valid` returns.
- **Slew, SHIFT=2:**
  - Stimulus: step from `y_n=0` to target +96.
  - Response: `y_n` = 24, 42, 55, 65, … reaching exactly 96, with no overshoot.
- **Max FCW / freeze:**
  - `fcw=32'hFFFF_FFFF` → `baud_stb` is high every cycle from cycle 2 onward.
  - Pull `en=0` for 5 cycles → `y_n`, `sym` and `acc` unchanged, and `baud_stb=0`.

Source files
------------

// File: rtl/cdr_symbol_tx.sv
// rtl/cdr_symbol_tx.sv - NCO-paced PRBS7/external symbol source with NRZ/PAM4 mapping and slew shaping
module cdr_symbol_tx #(
  parameter int AMP   = 96,
  parameter int SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [31:0]       fcw,
  input  logic              pam4,
  input  logic              src_ext,
  input  logic [1:0]        ext_sym,
  input  logic              ext_valid,
  output logic              ext_ready,
  output logic signed [7:0] y_n,
  output logic              baud_stb,
  output logic [1:0]        sym,
  output logic              underrun
);

  localparam logic signed [7:0] LVL_OUT = 8'(AMP);
  localparam logic signed [7:0] LVL_IN  = 8'(AMP / 3);
  localparam logic [8:0]        THR     = 9'(2 ** SHIFT);

  logic [31:0]       acc;
  logic [32:0]       sum;
  logic              tick;
  logic [6:0]        lfsr;
  logic [6:0]        lfsr_nxt;
  logic [6:0]        l1;
  logic              nb1;
  logic              nb2;
  logic [1:0]        sym_nxt;
  logic              fetch_ok;
  logic signed [7:0] target;
  logic signed [7:0] level_nxt;
  logic signed [7:0] y_nxt;
  logic signed [8:0] d;
  logic signed [8:0] step;
  logic signed [8:0] y_sum;
  logic [8:0]        abs_d;
  logic              stb_q;

  always_comb begin
    sum  = {1'b0, acc} + {1'b0, fcw};
    tick = en & sum[32];
  end

  // Symbol selection; PAM4 PRBS takes two LFSR steps, first bit is the MSB
  always_comb begin
    nb1      = lfsr[6] ^ lfsr[5];
    l1       = {lfsr[5:0], nb1};
    nb2      = l1[6] ^ l1[5];
    sym_nxt  = sym;
    lfsr_nxt = lfsr;
    fetch_ok = 1'b1;
    if (src_ext) begin
      fetch_ok = ext_valid;
      if (ext_valid)
        sym_nxt = pam4 ? ext_sym : {1'b0, ext_sym[0]};
    end else if (pam4) begin
      sym_nxt  = {nb1, nb2};
      lfsr_nxt = {l1[5:0], nb2};
    end else begin
      sym_nxt  = {1'b0, nb1};
      lfsr_nxt = l1;
    end
  end

  always_comb begin
    level_nxt = -LVL_OUT;
    if (pam4) begin
      case (sym_nxt)
        2'b00:   level_nxt = -LVL_OUT;
        2'b01:   level_nxt = -LVL_IN;
        2'b11:   level_nxt = LVL_IN;
        default: level_nxt = LVL_OUT;
      endcase
    end else begin
      level_nxt = sym_nxt[0] ? LVL_OUT : -LVL_OUT;
    end
  end

  // Shaped step never crosses the target, so the 8-bit truncation is exact
  always_comb begin
    d     = {target[7], target} - {y_n[7], y_n};
    abs_d = d[8] ? 9'(-d) : 9'(d);
    step  = d >>> SHIFT;
    y_sum = {y_n[7], y_n} + step;
    y_nxt = (abs_d < THR) ? target : y_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      lfsr     <= 7'h7F;
      sym      <= '0;
      target   <= '0;
      y_n      <= '0;
      stb_q    <= 1'b0;
      underrun <= 1'b0;
    end else if (en) begin
      acc   <= sum[31:0];
      stb_q <= tick;
      y_n   <= y_nxt;
      if (tick) begin
        sym  <= sym_nxt;
        lfsr <= lfsr_nxt;
        if (fetch_ok)
          target <= level_nxt;
        else
          underrun <= 1'b1;
      end
    end else begin
      stb_q <= 1'b0;
    end
  end

  assign baud_stb  = stb_q & en;
  assign ext_ready = tick & src_ext;

endmodule

// File: tb/tb_cdr_symbol_tx.sv
// tb/tb_cdr_symbol_tx.sv - directed bench for cdr_symbol_tx (SHIFT=0 and SHIFT=2 instances)
module tb_cdr_symbol_tx;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [31:0]       fcw;
  logic              pam4;
  logic              src_ext;
  logic [1:0]        ext_sym;
  logic              ext_valid;

  logic              ext_ready_a, baud_a, underrun_a;
  logic signed [7:0] y_a;
  logic [1:0]        sym_a;
  logic              ext_ready_b, baud_b, underrun_b;
  logic signed [7:0] y_b;
  logic [1:0]        sym_b;

  int tests = 0;
  int fails = 0;

  logic [1:0]        pam_syms [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic signed [7:0] pam_lvls [4] = '{8'sd96, 8'sd32, -8'sd32, -8'sd96};
  logic signed [7:0] slew_exp [15] = '{8'sd24, 8'sd42, 8'sd55, 8'sd65, 8'sd72, 8'sd78, 8'sd82,
                                        8'sd85, 8'sd87, 8'sd89, 8'sd90, 8'sd91, 8'sd92, 8'sd93, 8'sd96};

  cdr_symbol_tx #(.AMP(96), .SHIFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .fcw(fcw), .pam4(pam4), .src_ext(src_ext),
    .ext_sym(ext_sym), .ext_valid(ext_valid), .ext_ready(ext_ready_a), .y_n(y_a),
    .baud_stb(baud_a), .sym(sym_a), .underrun(underrun_a)
  );

  cdr_symbol_tx #(.AMP(96), .SHIFT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .fcw(fcw), .pam4(pam4), .src_ext(src_ext),
    .ext_sym(ext_sym), .ext_valid(ext_valid), .ext_ready(ext_ready_b), .y_n(y_b),
    .baud_stb(baud_b), .sym(sym_b), .underrun(underrun_b)
  );

  always #10 clk = ~clk;

  initial begin
    #400us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Release happens on a negedge; the cycle it starts in is cycle 0
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_baud(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      ok = baud_a;
    end
  endtask

  task automatic test_reset();
    en = 1'b1; fcw = 32'h4000_0000; src_ext = 1'b0; pam4 = 1'b0;
    ext_valid = 1'b0; ext_sym = 2'b00; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({y_a, sym_a, baud_a, underrun_a, ext_ready_a} !== 13'b0) begin
      fails++;
      $display("FAIL reset_outputs: got y=%0d sym=%b stb=%b urun=%b rdy=%b, want all 0",
               y_a, sym_a, baud_a, underrun_a, ext_ready_a);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      tests++;
      if (baud_a !== ((k % 4) == 0)) begin
        fails++;
        $display("FAIL reset_baud_cycle%0d: got %b want %b", k, baud_a, (k % 4) == 0);
      end
    end
  endtask

  task automatic test_nrz_prbs();
    logic [6:0]        m;
    logic              nb;
    logic              bits [254];
    logic signed [7:0] exp_y;
    bit                ok;
    int                bad_model, bad_lvl, bad_per;
    fcw = 32'h4000_0000; src_ext = 1'b0; pam4 = 1'b0; en = 1'b1;
    do_reset();
    m = 7'h7F; bad_model = 0; bad_lvl = 0; bad_per = 0;
    for (int i = 0; i < 254; i++) begin
      wait_baud(ok);
      if (!ok) begin
        tests++; fails++;
        $display("FAIL prbs_timeout: no baud_stb for symbol %0d", i);
        break;
      end
      nb = m[6] ^ m[5];
      m  = {m[5:0], nb};
      bits[i] = sym_a[0];
      if (sym_a !== {1'b0, nb}) begin
        if (bad_model == 0) $display("FAIL prbs_sym%0d: got %b want %b", i, sym_a, {1'b0, nb});
        bad_model++;
      end
      @(negedge clk);
      exp_y = nb ? 8'sd96 : -8'sd96;
      if (i < 7) begin
        tests++;
        if (y_a !== exp_y) begin
          fails++;
          $display("FAIL prbs_level%0d: got %0d want %0d", i, y_a, exp_y);
        end
      end else if (y_a !== exp_y) begin
        bad_lvl++;
      end
    end
    tests++;
    if (bad_model != 0) begin
      fails++;
      $display("FAIL prbs_sequence: %0d symbol errors, want 0", bad_model);
    end
    tests++;
    if (bad_lvl != 0) begin
      fails++;
      $display("FAIL prbs_levels: %0d level errors, want 0", bad_lvl);
    end
    for (int i = 0; i < 127; i++)
      if (bits[i] !== bits[i + 127]) bad_per++;
    tests++;
    if (bad_per != 0) begin
      fails++;
      $display("FAIL prbs_period127: %0d differing bits, want 0", bad_per);
    end
  endtask

  task automatic test_pam4_ext();
    int  n_rdy, cnt;
    bit  seen;
    fcw = 32'h4000_0000; src_ext = 1'b1; pam4 = 1'b1; ext_valid = 1'b1;
    ext_sym = pam_syms[0]; en = 1'b1;
    do_reset();
    n_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      ext_sym = pam_syms[i];
      seen = 1'b0; cnt = 0;
      while (!seen && cnt < 40) begin
        @(negedge clk);
        cnt++;
        if (ext_ready_a) n_rdy++;
        seen = baud_a;
      end
      if (!seen) begin
        tests++; fails++;
        $display("FAIL pam4_timeout: no baud_stb for symbol %0d", i);
        break;
      end
      tests++;
      if (sym_a !== pam_syms[i]) begin
        fails++;
        $display("FAIL pam4_sym%0d: got %b want %b", i, sym_a, pam_syms[i]);
      end
      @(negedge clk);
      if (ext_ready_a) n_rdy++;
      tests++;
      if (y_a !== pam_lvls[i]) begin
        fails++;
        $display("FAIL pam4_level%0d: got %0d want %0d", i, y_a, pam_lvls[i]);
      end
    end
    tests++;
    if (n_rdy != 4) begin
      fails++;
      $display("FAIL pam4_ready_count: got %0d want 4", n_rdy);
    end
  endtask

  task automatic test_underrun();
    bit ok;
    fcw = 32'h4000_0000; src_ext = 1'b1; pam4 = 1'b1; ext_valid = 1'b1;
    ext_sym = 2'b11; en = 1'b1;
    do_reset();
    wait_baud(ok);
    @(negedge clk);
    tests++;
    if (!ok || y_a !== 8'sd32 || underrun_a !== 1'b0) begin
      fails++;
      $display("FAIL underrun_pre: got ok=%b y=%0d urun=%b want ok=1 y=32 urun=0", ok, y_a, underrun_a);
    end
    ext_valid = 1'b0;
    wait_baud(ok);
    tests++;
    if (!ok || sym_a !== 2'b11 || underrun_a !== 1'b1) begin
      fails++;
      $display("FAIL underrun_hold: got ok=%b sym=%b urun=%b want ok=1 sym=11 urun=1", ok, sym_a, underrun_a);
    end
    @(negedge clk);
    tests++;
    if (y_a !== 8'sd32) begin
      fails++;
      $display("FAIL underrun_level: got %0d want 32", y_a);
    end
    ext_valid = 1'b1; ext_sym = 2'b10;
    wait_baud(ok);
    tests++;
    if (!ok || sym_a !== 2'b10 || underrun_a !== 1'b1) begin
      fails++;
      $display("FAIL underrun_sticky: got ok=%b sym=%b urun=%b want ok=1 sym=10 urun=1", ok, sym_a, underrun_a);
    end
    @(negedge clk);
    tests++;
    if (y_a !== 8'sd96) begin
      fails++;
      $display("FAIL underrun_resume: got %0d want 96", y_a);
    end
  endtask

  task automatic test_slew();
    bit ok;
    fcw = 32'h4000_0000; src_ext = 1'b1; pam4 = 1'b0; ext_valid = 1'b1;
    ext_sym = 2'b01; en = 1'b1;
    do_reset();
    wait_baud(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL slew_timeout: no baud_stb");
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      tests++;
      if (y_b !== slew_exp[i]) begin
        fails++;
        $display("FAIL slew_step%0d: got %0d want %0d", i, y_b, slew_exp[i]);
      end
    end
    @(negedge clk);
    tests++;
    if (y_b !== 8'sd96 || y_a !== 8'sd96) begin
      fails++;
      $display("FAIL slew_settle: got b=%0d a=%0d want 96 96", y_b, y_a);
    end
    ext_sym = 2'b00;
    wait_baud(ok);
    @(negedge clk);
    tests++;
    if (!ok || y_b !== 8'sd48 || y_a !== -8'sd96) begin
      fails++;
      $display("FAIL slew_down: got ok=%b b=%0d a=%0d want ok=1 b=48 a=-96", ok, y_b, y_a);
    end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({y_a, y_b, sym_a, sym_b, baud_a, baud_b} !== 22'b0) begin
      fails++;
      $display("FAIL async_reset: got ya=%0d yb=%0d syma=%b symb=%b stb=%b%b want all 0",
               y_a, y_b, sym_a, sym_b, baud_a, baud_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fcw_zero();
    int n;
    fcw = 32'h0; src_ext = 1'b1; pam4 = 1'b0; ext_valid = 1'b1; ext_sym = 2'b01; en = 1'b1;
    do_reset();
    n = 0;
    repeat (60) begin
      @(negedge clk);
      if (baud_a || ext_ready_a || y_a != 0) n++;
    end
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL fcw_zero: got %0d active cycles want 0", n);
    end
  endtask

  task automatic test_max_fcw();
    fcw = 32'hFFFF_FFFF; src_ext = 1'b0; pam4 = 1'b0; en = 1'b1;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      tests++;
      if (baud_a !== (k >= 2)) begin
        fails++;
        $display("FAIL maxfcw_baud_cycle%0d: got %b want %b", k, baud_a, k >= 2);
      end
    end
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (y_a !== -8'sd96 || sym_a !== 2'b00 || baud_a !== 1'b0 || dut_a.acc !== 32'hFFFF_FFF6) begin
        fails++;
        $display("FAIL freeze%0d: got y=%0d sym=%b stb=%b acc=%h want y=-96 sym=00 stb=0 acc=fffffff6",
                 k, y_a, sym_a, baud_a, dut_a.acc);
      end
    end
    en = 1'b1;
    @(negedge clk);
    tests++;
    if (baud_a !== 1'b1 || dut_a.acc !== 32'hFFFF_FFF5) begin
      fails++;
      $display("FAIL unfreeze: got stb=%b acc=%h want stb=1 acc=fffffff5", baud_a, dut_a.acc);
    end
  endtask

  initial begin
    test_reset();
    test_nrz_prbs();
    test_pam4_ext();
    test_underrun();
    test_slew();
    test_fcw_zero();
    test_max_fcw();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
